// File: rtl/switch_mcu_ahb_sram_slave_if.sv
// AHB-Lite bus bundle between the core's masters and the SRAM slave.
interface switch_mcu_ahb_sram_slave_if;
    logic        in_hsel;
    logic [31:0] in_haddr;
    logic [1:0]  in_htrans;
    logic        in_hwrite;
    logic [3:0]  in_hsize;
    logic [2:0]  in_hburst;
    logic [3:0]  in_hport;
    logic        in_hmastlock;
    logic [31:0] in_hwdata;
    logic        in_hreadyin;
    logic        out_hready;
    logic        out_hresp;
    logic [31:0] out_hrdata;

    modport master (
        output in_hsel, in_haddr, in_htrans, in_hwrite, in_hsize, in_hburst,
               in_hport, in_hmastlock, in_hwdata, in_hreadyin,
        input  out_hready, out_hresp, out_hrdata
    );

    modport slave (
        input  in_hsel, in_haddr, in_htrans, in_hwrite, in_hsize, in_hburst,
               in_hport, in_hmastlock, in_hwdata, in_hreadyin,
        output out_hready, out_hresp, out_hrdata
    );
endinterface

// File: rtl/switch_mcu_ahb_sram_slave.sv
// AHB-Lite slave with an internal word RAM, programmable wait states,
// byte/half/word lane-steered writes and the two-cycle ERROR response.
module switch_mcu_ahb_sram_slave #(
    parameter int unsigned ADDR_WIDTH  = 12,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int unsigned WAIT_STATES = 1,
    parameter bit          ACCEPT_BUSY = 1'b1,
    parameter bit          READ_ONLY   = 1'b0
) (
    input logic                         in_clk,
    input logic                         in_rst,
    switch_mcu_ahb_sram_slave_if.slave  bus
);
    localparam int unsigned Words = 2 ** (ADDR_WIDTH - 2);

    typedef enum logic [2:0] {StIdle, StWait, StData, StErr1, StErr2} state_e;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  write_q, write_d;
    logic [1:0]            size_q, size_d;
    logic [3:0]            cnt_q, cnt_d;
    logic [31:0]           mem [Words];

    logic       valid;
    logic       err;
    logic [3:0] lane_en;
    logic       unused_ok;

    // Burst, protection and lock carry no meaning for this slave.
    assign unused_ok = ^{bus.in_hburst, bus.in_hport, bus.in_hmastlock};

    // Address-phase decode: transfer qualification and error classification.
    always_comb begin
        logic in_window;
        logic bad_size;
        logic misaligned;
        valid = bus.in_hsel & bus.in_hreadyin &
                (bus.in_htrans[1] | (ACCEPT_BUSY && bus.in_htrans == 2'b01));
        in_window  = bus.in_haddr[31:ADDR_WIDTH] == BASE_ADDR[31:ADDR_WIDTH];
        bad_size   = bus.in_hsize > 4'd2;
        misaligned = (bus.in_hsize == 4'd1 && bus.in_haddr[0]) ||
                     (bus.in_hsize == 4'd2 && bus.in_haddr[1:0] != 2'b00);
        err = !in_window | bad_size | misaligned | (READ_ONLY && bus.in_hwrite);
    end

    // Next-state logic; new transfers are taken whenever the bus sees ready.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        write_d = write_q;
        size_d  = size_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle, StData, StErr2: begin
                state_d = StIdle;
                if (valid) begin
                    addr_d  = bus.in_haddr[ADDR_WIDTH-1:0];
                    write_d = bus.in_hwrite;
                    size_d  = bus.in_hsize[1:0];
                    if (err) begin
                        state_d = StErr1;
                    end else if (WAIT_STATES > 0) begin
                        state_d = StWait;
                        cnt_d   = 4'(WAIT_STATES - 1);
                    end else begin
                        state_d = StData;
                    end
                end
            end
            StWait: begin
                if (cnt_q == 4'd0) begin
                    state_d = StData;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            StErr1:  state_d = StErr2;
            default: state_d = StIdle;
        endcase
    end

    // State and transfer-attribute registers.
    always_ff @(posedge in_clk) begin
        if (in_rst) begin
            state_q <= StIdle;
            addr_q  <= '0;
            write_q <= 1'b0;
            size_q  <= 2'd0;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            write_q <= write_d;
            size_q  <= size_d;
            cnt_q   <= cnt_d;
        end
    end

    // Byte lanes touched by the registered write.
    always_comb begin
        unique case (size_q)
            2'd0:    lane_en = 4'b0001 << addr_q[1:0];
            2'd1:    lane_en = addr_q[1] ? 4'b1100 : 4'b0011;
            default: lane_en = 4'b1111;
        endcase
    end

    // RAM write at the end of the write data phase; contents survive reset.
    always_ff @(posedge in_clk) begin
        if (!in_rst && state_q == StData && write_q) begin
            for (int k = 0; k < 4; k++) begin
                if (lane_en[k]) begin
                    mem[addr_q[ADDR_WIDTH-1:2]][8*k +: 8] <= bus.in_hwdata[8*k +: 8];
                end
            end
        end
    end

    // Data-phase outputs; the RAM read is combinational off the registered address.
    always_comb begin
        bus.out_hready = !(state_q == StWait || state_q == StErr1);
        bus.out_hresp  = (state_q == StErr1 || state_q == StErr2);
        bus.out_hrdata = '0;
        if (state_q == StData && !write_q) begin
            bus.out_hrdata = mem[addr_q[ADDR_WIDTH-1:2]];
        end
    end
endmodule

// File: tb/tb_switch_mcu_ahb_sram_slave.sv
// Bench for the AHB SRAM slave: directed vector table, randomized traffic
// against a word-array model, and reset in the middle of a wait state.
module tb_switch_mcu_ahb_sram_slave;
    localparam int Ws0 = 1;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        which;
    logic        hsel;
    logic [31:0] haddr;
    logic [1:0]  htrans;
    logic        hwrite;
    logic [3:0]  hsize;
    logic [2:0]  hburst;
    logic [3:0]  hport;
    logic        hmastlock;
    logic [31:0] hwdata;

    switch_mcu_ahb_sram_slave_if bus0 ();
    switch_mcu_ahb_sram_slave_if bus1 ();

    assign bus0.in_hsel      = hsel & ~which;
    assign bus1.in_hsel      = hsel & which;
    assign bus0.in_haddr     = haddr;
    assign bus1.in_haddr     = haddr;
    assign bus0.in_htrans    = htrans;
    assign bus1.in_htrans    = htrans;
    assign bus0.in_hwrite    = hwrite;
    assign bus1.in_hwrite    = hwrite;
    assign bus0.in_hsize     = hsize;
    assign bus1.in_hsize     = hsize;
    assign bus0.in_hburst    = hburst;
    assign bus1.in_hburst    = hburst;
    assign bus0.in_hport     = hport;
    assign bus1.in_hport     = hport;
    assign bus0.in_hmastlock = hmastlock;
    assign bus1.in_hmastlock = hmastlock;
    assign bus0.in_hwdata    = hwdata;
    assign bus1.in_hwdata    = hwdata;
    assign bus0.in_hreadyin  = bus0.out_hready;
    assign bus1.in_hreadyin  = bus1.out_hready;

    switch_mcu_ahb_sram_slave dut0 (
        .in_clk (clk),
        .in_rst (rst),
        .bus    (bus0.slave)
    );

    switch_mcu_ahb_sram_slave #(
        .ADDR_WIDTH  (12),
        .BASE_ADDR   (32'h0000_4000),
        .WAIT_STATES (0),
        .ACCEPT_BUSY (1'b0),
        .READ_ONLY   (1'b1)
    ) dut1 (
        .in_clk (clk),
        .in_rst (rst),
        .bus    (bus1.slave)
    );

    typedef struct {
        bit          wh;
        bit          sel;
        logic [1:0]  tr;
        bit          wr;
        logic [3:0]  sz;
        logic [31:0] addr;
        logic [31:0] wd;
        int          ew;
        bit          er;
        bit          cd;
        logic [31:0] erd;
    } vec_t;

    int          n_vec = 0;
    int          n_bad = 0;
    vec_t        tbl[$];
    logic [31:0] model [64];

    function automatic vec_t mk(bit wh, bit sel, logic [1:0] tr, bit wr, logic [3:0] sz,
                                logic [31:0] addr, logic [31:0] wd, int ew, bit er, bit cd,
                                logic [31:0] erd);
        vec_t v;
        v.wh = wh; v.sel = sel; v.tr = tr; v.wr = wr; v.sz = sz; v.addr = addr; v.wd = wd;
        v.ew = ew; v.er = er; v.cd = cd; v.erd = erd;
        return v;
    endfunction

    function automatic logic cur_ready();
        return which ? bus1.out_hready : bus0.out_hready;
    endfunction

    function automatic logic cur_resp();
        return which ? bus1.out_hresp : bus0.out_hresp;
    endfunction

    function automatic logic [31:0] cur_rdata();
        return which ? bus1.out_hrdata : bus0.out_hrdata;
    endfunction

    // One transfer: address phase now (called at a negedge), then data phase until ready.
    task automatic xfer(input vec_t v, output int waits, output bit wresp, output bit resp,
                        output logic [31:0] rd, output bit side);
        which  = v.wh;
        hsel   = v.sel;
        htrans = v.tr;
        hwrite = v.wr;
        hsize  = v.sz;
        haddr  = v.addr;
        @(negedge clk);
        hsel   = 1'b0;
        htrans = 2'b00;
        hwdata = v.wd;
        waits  = 0;
        wresp  = 1'b0;
        side   = 1'b0;
        while (cur_ready() !== 1'b1 && waits < 32) begin
            wresp = wresp | (cur_resp() === 1'b1);
            if (cur_rdata() !== 32'h0) side = 1'b1;
            waits++;
            @(negedge clk);
        end
        resp = cur_resp();
        rd   = cur_rdata();
    endtask

    task automatic run_vec(input string tag, input vec_t v);
        int          w;
        bit          wr_resp;
        bit          r;
        bit          sb;
        logic [31:0] rd;
        bit          ok;
        bit          exp_wresp;
        xfer(v, w, wr_resp, r, rd, sb);
        exp_wresp = (v.ew > 0) ? v.er : 1'b0;
        ok = (w == v.ew) && (wr_resp == exp_wresp) && (r == v.er) && !sb &&
             (!v.cd || rd === v.erd);
        n_vec++;
        if (!ok) begin
            n_bad++;
            $display("FAIL %s addr=%08h wr=%0b sz=%0d: got waits=%0d wresp=%0b resp=%0b rdata=%08h side=%0b, want waits=%0d resp=%0b rdata=%08h",
                     tag, v.addr, v.wr, v.sz, w, wr_resp, r, rd, sb, v.ew, v.er, v.erd);
        end
    endtask

    task automatic check_idle_out(input string tag, input logic rdy, input logic rsp,
                                  input logic [31:0] rdat);
        n_vec++;
        if (rdy !== 1'b1 || rsp !== 1'b0 || rdat !== 32'h0) begin
            n_bad++;
            $display("FAIL %s: got hready=%0b hresp=%0b hrdata=%08h, want 1 0 00000000",
                     tag, rdy, rsp, rdat);
        end
    endtask

    // Reference for dut0: 4 KiB window at 0, one wait state, writable, busy accepted.
    function automatic vec_t model_vec(bit sel, logic [1:0] tr, bit wr, logic [3:0] sz,
                                       logic [31:0] a, logic [31:0] wd);
        vec_t        v;
        bit          is_valid;
        bit          is_err;
        int unsigned idx;
        v = mk(1'b0, sel, tr, wr, sz, a, wd, 0, 1'b0, 1'b1, 32'h0);
        is_valid = sel && (tr != 2'b00);
        is_err   = (a >= 32'h1000) || (sz > 4'd2) ||
                   ((sz <= 4'd2) && ((a & ((32'd1 << sz) - 32'd1)) != 32'd0));
        if (!is_valid) return v;
        if (is_err) begin
            v.ew = 1;
            v.er = 1'b1;
            return v;
        end
        v.ew = Ws0;
        idx  = a[7:2];
        if (wr) begin
            for (int k = 0; k < 4; k++) begin
                if ((k >> sz) == (int'(a[1:0]) >> sz)) model[idx][8*k +: 8] = wd[8*k +: 8];
            end
        end else begin
            v.erd = model[idx];
        end
        return v;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, n_vec=%0d", n_vec);
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;
        rst = 1'b1; which = 1'b0; hsel = 1'b0; haddr = '0; htrans = 2'b00; hwrite = 1'b0;
        hsize = 4'd2; hburst = 3'd0; hport = 4'd0; hmastlock = 1'b0; hwdata = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check_idle_out("reset_dut0", bus0.out_hready, bus0.out_hresp, bus0.out_hrdata);
        check_idle_out("reset_dut1", bus1.out_hready, bus1.out_hresp, bus1.out_hrdata);

        // Directed table.
        tbl.push_back(mk(0, 1, 2'd2, 1, 4'd2, 32'h10, 32'hDEADBEEF, 1, 0, 1, 32'h0));
        tbl.push_back(mk(0, 1, 2'd2, 0, 4'd2, 32'h10, 32'h0, 1, 0, 1, 32'hDEADBEEF));
        tbl.push_back(mk(0, 1, 2'd2, 1, 4'd2, 32'h10, 32'h11223344, 1, 0, 1, 32'h0));
        tbl.push_back(mk(0, 1, 2'd2, 1, 4'd0, 32'h13, 32'hAAFFFFFF, 1, 0, 1, 32'h0));
        tbl.push_back(mk(0, 1, 2'd2, 0, 4'd2, 32'h10, 32'h0, 1, 0, 1, 32'hAA223344));
        tbl.push_back(mk(0, 1, 2'd2, 1, 4'd1, 32'h10, 32'hFFFF5566, 1, 0, 1, 32'h0));
        tbl.push_back(mk(0, 1, 2'd2, 0, 4'd2, 32'h10, 32'h0, 1, 0, 1, 32'hAA225566));
        tbl.push_back(mk(0, 1, 2'd2, 0, 4'd2, 32'h02, 32'h0, 1, 1, 1, 32'h0));
        tbl.push_back(mk(0, 1, 2'd2, 1, 4'd2, 32'h12, 32'h0, 1, 1, 1, 32'h0));
        tbl.push_back(mk(0, 1, 2'd2, 0, 4'd2, 32'h1000, 32'h0, 1, 1, 1, 32'h0));
        tbl.push_back(mk(0, 1, 2'd2, 1, 4'd2, 32'h1000, 32'h0, 1, 1, 1, 32'h0));
        tbl.push_back(mk(0, 1, 2'd2, 0, 4'd3, 32'h10, 32'h0, 1, 1, 1, 32'h0));
        tbl.push_back(mk(0, 1, 2'd2, 1, 4'd1, 32'h11, 32'h0, 1, 1, 1, 32'h0));
        tbl.push_back(mk(0, 1, 2'd2, 0, 4'd2, 32'h10, 32'h0, 1, 0, 1, 32'hAA225566));
        tbl.push_back(mk(0, 1, 2'd2, 1, 4'd2, 32'h04, 32'h00000013, 1, 0, 1, 32'h0));
        tbl.push_back(mk(0, 1, 2'd1, 0, 4'd2, 32'h04, 32'h0, 1, 0, 1, 32'h00000013));
        tbl.push_back(mk(0, 0, 2'd2, 0, 4'd2, 32'h04, 32'h0, 0, 0, 1, 32'h0));
        tbl.push_back(mk(0, 1, 2'd0, 0, 4'd2, 32'h04, 32'h0, 0, 0, 1, 32'h0));
        tbl.push_back(mk(0, 1, 2'd2, 1, 4'd2, 32'h08, 32'hCAFEF00D, 1, 0, 1, 32'h0));
        tbl.push_back(mk(0, 1, 2'd3, 0, 4'd2, 32'h08, 32'h0, 1, 0, 1, 32'hCAFEF00D));
        tbl.push_back(mk(0, 1, 2'd2, 1, 4'd0, 32'h09, 32'h00007700, 1, 0, 1, 32'h0));
        tbl.push_back(mk(0, 1, 2'd2, 1, 4'd1, 32'h0A, 32'h1234FFFF, 1, 0, 1, 32'h0));
        tbl.push_back(mk(0, 1, 2'd2, 0, 4'd2, 32'h08, 32'h0, 1, 0, 1, 32'h1234770D));
        tbl.push_back(mk(1, 1, 2'd2, 1, 4'd2, 32'h4000, 32'h0, 1, 1, 1, 32'h0));
        tbl.push_back(mk(1, 1, 2'd1, 0, 4'd2, 32'h4004, 32'h0, 0, 0, 1, 32'h0));
        tbl.push_back(mk(1, 1, 2'd2, 0, 4'd2, 32'h4006, 32'h0, 1, 1, 1, 32'h0));
        tbl.push_back(mk(1, 1, 2'd2, 0, 4'd2, 32'h0000, 32'h0, 1, 1, 1, 32'h0));
        tbl.push_back(mk(1, 1, 2'd2, 0, 4'd2, 32'h5000, 32'h0, 1, 1, 1, 32'h0));
        tbl.push_back(mk(1, 1, 2'd2, 0, 4'd0, 32'h4003, 32'h0, 0, 0, 0, 32'h0));
        tbl.push_back(mk(1, 1, 2'd2, 1, 4'd0, 32'h4001, 32'h0, 1, 1, 1, 32'h0));
        tbl.push_back(mk(0, 1, 2'd2, 0, 4'd2, 32'h10, 32'h0, 1, 0, 1, 32'hAA225566));
        for (int i = 0; i < tbl.size(); i++) begin
            run_vec($sformatf("vec%0d", i), tbl[i]);
        end

        // Fill the modelled region, then random traffic against the model.
        for (int i = 0; i < 64; i++) begin
            v = model_vec(1'b1, 2'd2, 1'b1, 4'd2, 32'(i * 4), $urandom);
            run_vec("fill", v);
        end
        for (int i = 0; i < 300; i++) begin
            logic [31:0] a;
            logic [3:0]  sz;
            hburst    = 3'($urandom);
            hport     = 4'($urandom);
            hmastlock = 1'($urandom);
            a  = ($urandom_range(0, 9) == 0) ? ($urandom | 32'h1000) : 32'($urandom_range(0, 255));
            sz = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(3, 15)) : 4'($urandom_range(0, 2));
            v  = model_vec($urandom_range(0, 9) != 0, 2'($urandom), 1'($urandom), sz, a, $urandom);
            run_vec($sformatf("rand%0d", i), v);
        end

        // Reset while a write to 0x20 sits in its wait state: the write must be dropped.
        which = 1'b0; hsel = 1'b1; htrans = 2'd2; hwrite = 1'b1; hsize = 4'd2; haddr = 32'h20;
        @(negedge clk);
        hsel = 1'b0; htrans = 2'd0; hwdata = ~model[8]; rst = 1'b1;
        @(negedge clk);
        check_idle_out("rst_mid_wait", bus0.out_hready, bus0.out_hresp, bus0.out_hrdata);
        rst = 1'b0;
        run_vec("read_after_rst", mk(0, 1, 2'd2, 0, 4'd2, 32'h20, 32'h0, 1, 0, 1, model[8]));

        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
